// File: rtl/router_fsm_np.sv
// Packet-router control FSM: decodes the header address, sequences payload/parity writes,
// stalls on a busy or full FIFO, and drops packets addressed to a nonexistent port.
module router_fsm_np #(
    parameter int NUM_PORTS    = 3,
    parameter int ADDR_W       = 2,
    parameter int WAIT_TIMEOUT = 0
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 rst_int_reg,
    output logic                 write_enb_reg,
    output logic                 busy,
    output logic                 drop_state,
    output logic [ADDR_W-1:0]    port_sel,
    output logic                 timeout_err
);

    typedef enum logic [3:0] {
        DECODE_ADDRESS,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        WAIT_TILL_EMPTY,
        LOAD_PARITY,
        CHECK_PARITY_ERROR,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        DROP_PACKET
    } state_t;

    localparam int                PORTS_X     = 2 ** ADDR_W;
    localparam int                CNT_W       = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
    localparam logic [ADDR_W:0]   NUM_PORTS_X = (ADDR_W + 1)'(NUM_PORTS);
    localparam logic [CNT_W-1:0]  CNT_LAST    = (WAIT_TIMEOUT > 0) ? CNT_W'(WAIT_TIMEOUT - 1) : '0;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   port_sel_q, port_sel_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                timeout_q, timeout_d;
    logic [PORTS_X-1:0]  empty_ext, srst_ext;

    logic detect_add_q, lfd_q, ld_q, laf_q, full_q, rst_int_q, wen_q, busy_q, drop_q;

    always_comb begin
        // Widen per-port flags to the full address space so any port_sel/data_in indexes safely.
        empty_ext                = '0;
        empty_ext[NUM_PORTS-1:0] = fifo_empty;
        srst_ext                 = '0;
        srst_ext[NUM_PORTS-1:0]  = soft_reset;

        state_d    = state_q;
        port_sel_d = port_sel_q;
        timeout_d  = 1'b0;

        case (state_q)
            DECODE_ADDRESS: begin
                if (pkt_valid) begin
                    port_sel_d = data_in;
                    if ({1'b0, data_in} >= NUM_PORTS_X)
                        state_d = DROP_PACKET;
                    else if (empty_ext[data_in])
                        state_d = LOAD_FIRST_DATA;
                    else
                        state_d = WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)
                    state_d = FIFO_FULL_STATE;
                else if (!pkt_valid)
                    state_d = LOAD_PARITY;
            end
            WAIT_TILL_EMPTY: begin
                if (empty_ext[port_sel_q]) begin
                    state_d = LOAD_FIRST_DATA;
                end else if (WAIT_TIMEOUT > 0 && cnt_q == CNT_LAST) begin
                    state_d   = DROP_PACKET;
                    timeout_d = 1'b1;
                end
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            FIFO_FULL_STATE: begin
                if (!fifo_full)
                    state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)
                    state_d = DECODE_ADDRESS;
                else if (low_pkt_valid)
                    state_d = LOAD_PARITY;
                else
                    state_d = LOAD_DATA;
            end
            DROP_PACKET: begin
                if (!pkt_valid)
                    state_d = DECODE_ADDRESS;
            end
            default: state_d = DECODE_ADDRESS;
        endcase

        if (state_q != DECODE_ADDRESS && srst_ext[port_sel_q]) begin
            state_d   = DECODE_ADDRESS;
            timeout_d = 1'b0;
        end

        // Counter runs only while staying in WAIT_TILL_EMPTY, so every entry starts from zero.
        if (WAIT_TIMEOUT > 0 && state_q == WAIT_TILL_EMPTY && state_d == WAIT_TILL_EMPTY)
            cnt_d = cnt_q + CNT_W'(1);
        else
            cnt_d = '0;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= DECODE_ADDRESS;
            port_sel_q   <= '0;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
            detect_add_q <= 1'b1;
            lfd_q        <= 1'b0;
            ld_q         <= 1'b0;
            laf_q        <= 1'b0;
            full_q       <= 1'b0;
            rst_int_q    <= 1'b0;
            wen_q        <= 1'b0;
            busy_q       <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            port_sel_q   <= port_sel_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
            detect_add_q <= (state_d == DECODE_ADDRESS);
            lfd_q        <= (state_d == LOAD_FIRST_DATA);
            ld_q         <= (state_d == LOAD_DATA);
            laf_q        <= (state_d == LOAD_AFTER_FULL);
            full_q       <= (state_d == FIFO_FULL_STATE);
            rst_int_q    <= (state_d == CHECK_PARITY_ERROR);
            wen_q        <= (state_d == LOAD_DATA) || (state_d == LOAD_PARITY) ||
                            (state_d == LOAD_AFTER_FULL);
            // Dropping keeps busy low so the upstream source drains the packet at full rate.
            busy_q       <= !((state_d == DECODE_ADDRESS) || (state_d == LOAD_DATA) ||
                              (state_d == DROP_PACKET));
            drop_q       <= (state_d == DROP_PACKET);
        end
    end

    assign detect_add    = detect_add_q;
    assign lfd_state     = lfd_q;
    assign ld_state      = ld_q;
    assign laf_state     = laf_q;
    assign full_state    = full_q;
    assign rst_int_reg   = rst_int_q;
    assign write_enb_reg = wen_q;
    assign busy          = busy_q;
    assign drop_state    = drop_q;
    assign port_sel      = port_sel_q;
    assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_router_fsm_np.sv
// Directed bench for router_fsm_np (3 ports, 2-bit address, 8-cycle wait timeout);
// expected state/port/timeout per cycle are queued with the stimulus and checked after each edge.
module tb_router_fsm_np;

    typedef enum int {S_DA, S_LFD, S_LD, S_WTE, S_LP, S_CPE, S_FFS, S_LAF, S_DROP} st_t;

    typedef struct {
        st_t        st;
        logic [1:0] ps;
        logic       terr;
        string      tag;
    } exp_t;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] soft_reset;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       rst_int_reg, write_enb_reg, busy, drop_state;
    logic [1:0] port_sel;
    logic       timeout_err;

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;
    int   wen_cnt;
    int   terr_cnt;

    router_fsm_np #(
        .NUM_PORTS   (3),
        .ADDR_W      (2),
        .WAIT_TIMEOUT(8)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .pkt_valid    (pkt_valid),
        .data_in      (data_in),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .soft_reset   (soft_reset),
        .parity_done  (parity_done),
        .low_pkt_valid(low_pkt_valid),
        .detect_add   (detect_add),
        .lfd_state    (lfd_state),
        .ld_state     (ld_state),
        .laf_state    (laf_state),
        .full_state   (full_state),
        .rst_int_reg  (rst_int_reg),
        .write_enb_reg(write_enb_reg),
        .busy         (busy),
        .drop_state   (drop_state),
        .port_sel     (port_sel),
        .timeout_err  (timeout_err)
    );

    always #5 clock = ~clock;

    // Bit order: detect_add lfd ld laf full rst_int wen busy drop
    function automatic logic [8:0] decode(input st_t s);
        case (s)
            S_DA:    return 9'b100000000;
            S_LFD:   return 9'b010000010;
            S_LD:    return 9'b001000100;
            S_WTE:   return 9'b000000010;
            S_LP:    return 9'b000000110;
            S_CPE:   return 9'b000001010;
            S_FFS:   return 9'b000010010;
            S_LAF:   return 9'b000100110;
            S_DROP:  return 9'b000000001;
            default: return 9'bx;
        endcase
    endfunction

    task automatic chk(input string tag, input int observed, input int expected);
        total++;
        assert (observed === expected) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_out();
        exp_t       e;
        logic [8:0] obs;
        e   = exp_q.pop_front();
        obs = {detect_add, lfd_state, ld_state, laf_state, full_state,
               rst_int_reg, write_enb_reg, busy, drop_state};
        total++;
        assert (obs === decode(e.st)) begin
            passed++;
        end else begin
            $error("FAIL %s outputs: observed %b expected %b", e.tag, obs, decode(e.st));
        end
        total++;
        assert (port_sel === e.ps) begin
            passed++;
        end else begin
            $error("FAIL %s port_sel: observed %0d expected %0d", e.tag, port_sel, e.ps);
        end
        total++;
        assert (timeout_err === e.terr) begin
            passed++;
        end else begin
            $error("FAIL %s timeout_err: observed %b expected %b", e.tag, timeout_err, e.terr);
        end
        if (write_enb_reg === 1'b1) wen_cnt++;
        if (timeout_err === 1'b1) terr_cnt++;
    endtask

    // Queue the state expected after the coming edge, clock it, then check away from the edge.
    task automatic step(input st_t st, input logic [1:0] ps, input logic terr, input string tag);
        exp_t e;
        e.st   = st;
        e.ps   = ps;
        e.terr = terr;
        e.tag  = tag;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        check_out();
    endtask

    initial begin
        resetn        = 1'b0;
        pkt_valid     = 1'b0;
        data_in       = 2'd0;
        fifo_full     = 1'b0;
        fifo_empty    = 3'b111;
        soft_reset    = 3'b000;
        parity_done   = 1'b0;
        low_pkt_valid = 1'b0;
        wen_cnt       = 0;
        terr_cnt      = 0;

        step(S_DA, 2'd0, 1'b0, "reset0");
        step(S_DA, 2'd0, 1'b0, "reset1");
        resetn = 1'b1;
        step(S_DA, 2'd0, 1'b0, "idle");

        // Normal packet to port 1, four payload bytes
        wen_cnt   = 0;
        pkt_valid = 1'b1;
        data_in   = 2'd1;
        step(S_LFD, 2'd1, 1'b0, "s1_hdr");
        step(S_LD,  2'd1, 1'b0, "s1_p1");
        step(S_LD,  2'd1, 1'b0, "s1_p2");
        step(S_LD,  2'd1, 1'b0, "s1_p3");
        step(S_LD,  2'd1, 1'b0, "s1_p4");
        pkt_valid = 1'b0;
        step(S_LP,  2'd1, 1'b0, "s1_par");
        step(S_CPE, 2'd1, 1'b0, "s1_cpe");
        step(S_DA,  2'd1, 1'b0, "s1_done");
        chk("s1_wen_cycles", wen_cnt, 5);

        // Port 2 busy: wait only on fifo_empty[2]
        pkt_valid  = 1'b1;
        data_in    = 2'd2;
        fifo_empty = 3'b011;
        step(S_WTE, 2'd2, 1'b0, "s2_hdr");
        pkt_valid  = 1'b0;
        fifo_empty = 3'b000;
        step(S_WTE, 2'd2, 1'b0, "s2_wait_000");
        fifo_empty = 3'b001;
        step(S_WTE, 2'd2, 1'b0, "s2_wait_001");
        fifo_empty = 3'b010;
        step(S_WTE, 2'd2, 1'b0, "s2_wait_010");
        fifo_empty = 3'b100;
        pkt_valid  = 1'b1;
        step(S_LFD, 2'd2, 1'b0, "s2_empty");
        data_in    = 2'd0;
        step(S_LD,  2'd2, 1'b0, "s2_ps_hold");
        pkt_valid  = 1'b0;
        step(S_LP,  2'd2, 1'b0, "s2_par");
        step(S_CPE, 2'd2, 1'b0, "s2_cpe");
        step(S_DA,  2'd2, 1'b0, "s2_done");

        // Address 3 does not exist: drop without writes
        wen_cnt    = 0;
        fifo_empty = 3'b111;
        pkt_valid  = 1'b1;
        data_in    = 2'd3;
        step(S_DROP, 2'd3, 1'b0, "s3_hdr");
        data_in    = 2'd1;
        step(S_DROP, 2'd3, 1'b0, "s3_p1");
        step(S_DROP, 2'd3, 1'b0, "s3_p2");
        pkt_valid  = 1'b0;
        step(S_DA,   2'd3, 1'b0, "s3_done");
        chk("s3_no_writes", wen_cnt, 0);

        // Port 0 never drains: timeout after 8 wait cycles
        terr_cnt   = 0;
        fifo_empty = 3'b110;
        pkt_valid  = 1'b1;
        data_in    = 2'd0;
        step(S_WTE, 2'd0, 1'b0, "s4_hdr");
        pkt_valid  = 1'b0;
        for (int i = 0; i < 7; i++) step(S_WTE, 2'd0, 1'b0, "s4_wait");
        step(S_DROP, 2'd0, 1'b1, "s4_timeout");
        step(S_DA,   2'd0, 1'b0, "s4_done");
        step(S_DA,   2'd0, 1'b0, "s4_idle");
        chk("s4_timeout_pulses", terr_cnt, 1);

        // Full FIFO mid-packet, then resume with low_pkt_valid
        fifo_empty = 3'b111;
        pkt_valid  = 1'b1;
        data_in    = 2'd1;
        step(S_LFD, 2'd1, 1'b0, "s5_hdr");
        step(S_LD,  2'd1, 1'b0, "s5_p1");
        fifo_full  = 1'b1;
        step(S_FFS, 2'd1, 1'b0, "s5_full");
        step(S_FFS, 2'd1, 1'b0, "s5_full_hold");
        fifo_full     = 1'b0;
        low_pkt_valid = 1'b1;
        pkt_valid     = 1'b0;
        step(S_LAF, 2'd1, 1'b0, "s5_release");
        step(S_LP,  2'd1, 1'b0, "s5_laf_lp");
        low_pkt_valid = 1'b0;
        step(S_CPE, 2'd1, 1'b0, "s5_cpe");
        step(S_DA,  2'd1, 1'b0, "s5_done");

        // Soft reset: other port ignored, own port aborts, ignored in DECODE
        pkt_valid  = 1'b1;
        data_in    = 2'd1;
        step(S_LFD, 2'd1, 1'b0, "s6_hdr");
        step(S_LD,  2'd1, 1'b0, "s6_p1");
        soft_reset = 3'b101;
        step(S_LD,  2'd1, 1'b0, "s6_other_port");
        soft_reset = 3'b010;
        step(S_DA,  2'd1, 1'b0, "s6_own_port");
        soft_reset = 3'b111;
        data_in    = 2'd2;
        step(S_LFD, 2'd2, 1'b0, "s6_decode_ignored");
        soft_reset = 3'b000;
        step(S_LD,  2'd2, 1'b0, "s6_p1b");

        // Hard reset mid-packet wins over a concurrent soft reset
        resetn     = 1'b0;
        soft_reset = 3'b100;
        step(S_DA, 2'd0, 1'b0, "s7_reset_mid");
        resetn     = 1'b1;
        soft_reset = 3'b000;
        pkt_valid  = 1'b0;
        step(S_DA, 2'd0, 1'b0, "s7_idle");

        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/router_fsm_np.md
ROUTER_FSM_NP -- requirements
Module: router_fsm_np

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 3: number of output ports/FIFOs, 2..2**ADDR_W.
REQ-002 SHALL have parameter ADDR_W, default 2: width of the header destination-address field.
REQ-003 SHALL have parameter WAIT_TIMEOUT, default 0: maximum WAIT_TILL_EMPTY cycles; 0 disables the timeout.
REQ-004 SHALL have port clock, input, 1: rising-edge clock.
REQ-005 SHALL have port resetn, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port pkt_valid, input, 1: header/payload byte valid.
REQ-007 SHALL have port data_in, input, ADDR_W: destination-address bits of the header byte.
REQ-008 SHALL have port fifo_full, input, 1: full flag of the addressed FIFO.
REQ-009 SHALL have port fifo_empty, input, NUM_PORTS: per-port FIFO empty flags.
REQ-010 SHALL have port soft_reset, input, NUM_PORTS: per-port soft-reset requests.
REQ-011 SHALL have ports parity_done and low_pkt_valid, input, 1 each: from the register block.
REQ-012 SHALL have outputs detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg, busy, drop_state, 1 bit each: state decodes.
REQ-013 SHALL have output port_sel, ADDR_W: latched destination port.
REQ-014 SHALL have output timeout_err, 1: one-cycle pulse on a wait timeout.

Function
REQ-015 SHALL implement a Moore FSM with nine states: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, WAIT_TILL_EMPTY, LOAD_PARITY, CHECK_PARITY_ERROR, FIFO_FULL_STATE, LOAD_AFTER_FULL, DROP_PACKET.
REQ-016 SHALL latch data_in into port_sel on any DECODE_ADDRESS cycle with pkt_valid=1; port_sel SHALL hold otherwise.
REQ-017 SHALL transition out of DECODE_ADDRESS when pkt_valid=1: data_in>=NUM_PORTS -> DROP_PACKET; fifo_empty[data_in]=1 -> LOAD_FIRST_DATA; else -> WAIT_TILL_EMPTY.
REQ-018 SHALL remain in DECODE_ADDRESS when pkt_valid=0.
REQ-019 SHALL transition LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
REQ-020 SHALL transition out of LOAD_DATA: fifo_full=1 -> FIFO_FULL_STATE; else pkt_valid=0 -> LOAD_PARITY; else stay.
REQ-021 SHALL transition out of WAIT_TILL_EMPTY based only on fifo_empty[port_sel]: 1 -> LOAD_FIRST_DATA; 0 -> stay.
REQ-022 SHALL, when WAIT_TIMEOUT>0 and the wait counter reaches WAIT_TIMEOUT with fifo_empty[port_sel] still 0, transition WAIT_TILL_EMPTY -> DROP_PACKET and pulse timeout_err for one cycle.
REQ-023 SHALL clear the wait counter on every entry to WAIT_TILL_EMPTY; the counter SHALL be wide enough never to wrap before WAIT_TIMEOUT.
REQ-024 SHALL transition LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
REQ-025 SHALL transition out of CHECK_PARITY_ERROR: fifo_full=1 -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
REQ-026 SHALL transition out of FIFO_FULL_STATE: fifo_full=0 -> LOAD_AFTER_FULL; else stay.
REQ-027 SHALL transition out of LOAD_AFTER_FULL: parity_done=1 -> DECODE_ADDRESS; else low_pkt_valid=1 -> LOAD_PARITY; else -> LOAD_DATA.
REQ-028 SHALL remain in DROP_PACKET while pkt_valid=1 and, on the cycle after pkt_valid=0 (parity byte), go to DECODE_ADDRESS; no write enable SHALL be asserted while dropping.
REQ-029 SHALL decode outputs from state only: detect_add=DECODE_ADDRESS; lfd_state=LOAD_FIRST_DATA; ld_state=LOAD_DATA; laf_state=LOAD_AFTER_FULL; full_state=FIFO_FULL_STATE; rst_int_reg=CHECK_PARITY_ERROR; drop_state=DROP_PACKET.
REQ-030 SHALL assert write_enb_reg in LOAD_DATA, LOAD_PARITY and LOAD_AFTER_FULL.
REQ-031 SHALL assert busy in all states except DECODE_ADDRESS, LOAD_DATA and DROP_PACKET, so a dropped packet drains at full rate.
REQ-032 SHALL, when soft_reset[port_sel]=1 in any state other than DECODE_ADDRESS, force the next state to DECODE_ADDRESS and clear the wait counter; soft_reset bits of other ports, and all soft_reset bits in DECODE_ADDRESS, SHALL be ignored.
REQ-033 SHALL give resetn priority over soft_reset when both are active.

Reset
REQ-034 SHALL, on resetn=0 at a rising edge, enter DECODE_ADDRESS with port_sel=0, wait counter=0 and timeout_err=0, leaving detect_add=1 and every other output 0; this SHALL hold when applied mid-packet.

Verification
REQ-035 SHALL cover: NUM_PORTS=3, header addr 1 with fifo_empty=3'b111, 4 payload bytes -> DECODE, LFD, LD x4, LP, CPE, DECODE; write_enb_reg=1 for 5 cycles.
REQ-036 SHALL cover: addr 2 with fifo_empty=3'b011 -> WAIT_TILL_EMPTY until fifo_empty[2]=1, irrespective of bits 0/1.
REQ-037 SHALL cover: NUM_PORTS=3, addr 3 -> DROP_PACKET, drop_state=1, busy=0, write_enb_reg=0 throughout, DECODE one cycle after pkt_valid falls.
REQ-038 SHALL cover: WAIT_TIMEOUT=8 with fifo_empty[port_sel] held 0 -> exactly one timeout_err pulse, then DROP_PACKET.
REQ-039 SHALL cover: fifo_full=1 in LOAD_DATA -> FFS; release with parity_done=0 and low_pkt_valid=1 -> LAF then LP.
REQ-040 SHALL cover: soft_reset[port_sel] in LOAD_DATA -> DECODE next cycle; soft_reset on another port -> no effect.
